// File: rtl/mem_arbiter.sv
// Shares one byte-addressed RAM between instruction fetch and load/store, MEM first.
// Sequences each access IDLE -> ACCESS -> RESP and returns extended load data with a done pulse.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_done_o,
    output logic        if_stall_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_stall_o,
    output logic        bus_err_o,
    output logic        ram_valid_o,
    output logic        ram_write_o,
    output logic [3:0]  ram_byte_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_store_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_busy_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(WAIT_CYCLES - 1);
    localparam logic [CntW-1:0] TmoLast  = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e          state_q, state_d;
    logic            owner_mem_q, owner_mem_d;
    logic            we_q, we_d;
    logic [2:0]      f3_q, f3_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    function automatic logic [31:0] load_ext(logic we, logic [2:0] f3, logic [31:0] d);
        logic [31:0] r;
        if (we) begin
            r = 32'h0;
        end else begin
            unique case (f3)
                3'b000:  r = {{24{d[7]}}, d[7:0]};
                3'b001:  r = {{16{d[15]}}, d[15:0]};
                3'b100:  r = {24'h0, d[7:0]};
                3'b101:  r = {16'h0, d[15:0]};
                default: r = d;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            data_q      <= 32'h0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_req_i) begin
                    owner_mem_d = 1'b1;
                    we_d        = mem_we_i;
                    f3_d        = mem_funct3_i;
                    addr_d      = mem_addr_i;
                    wdata_d     = mem_wdata_i;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = StAccess;
                end else if (if_req_i) begin
                    // Fetches are full-word reads, encoded as a plain LW.
                    owner_mem_d = 1'b0;
                    we_d        = 1'b0;
                    f3_d        = 3'b010;
                    addr_d      = if_addr_i;
                    wdata_d     = 32'h0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 1'b1;
                if (!ram_busy_i && cnt_q >= WaitLast) begin
                    data_d  = load_ext(we_q, f3_q, ram_data_i);
                    state_d = StResp;
                end else if (cnt_q == TmoLast) begin
                    data_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    logic       in_access, in_resp;
    logic [3:0] lanes;

    always_comb begin
        in_access = (state_q == StAccess);
        in_resp   = (state_q == StResp);
        lanes     = 4'b1111;
        if (owner_mem_q) begin
            unique case (f3_q[1:0])
                2'b00:   lanes = 4'b0001;
                2'b01:   lanes = 4'b0011;
                default: lanes = 4'b1111;
            endcase
        end
        ram_valid_o      = in_access;
        ram_write_o      = in_access & we_q;
        ram_byte_o       = in_access ? lanes : 4'b0000;
        ram_addr_o       = in_access ? addr_q : 32'h0;
        ram_store_data_o = in_access ? wdata_q : 32'h0;
        mem_done_o       = in_resp & owner_mem_q;
        if_done_o        = in_resp & ~owner_mem_q;
        bus_err_o        = in_resp & err_q;
        mem_rdata_o      = mem_done_o ? data_q : 32'h0;
        if_inst_o        = if_done_o ? data_q : 32'h0;
        // Gated by reset so every output reads zero while reset is held.
        if_stall_o       = rst_ni & if_req_i & ~if_done_o;
        mem_stall_o      = rst_ni & mem_req_i & ~mem_done_o;
    end

endmodule
